// File: rtl/mc_core.sv
// mc_core: parametrised multicycle core with FETCH/DECODE/EXEC/MEM
// sequencing and req/ack handshakes to instruction and data memories.
module mc_core #(
   parameter int DW   = 8,
   parameter int NREG = 8,
   parameter int PAW  = 8,
   parameter int DAW  = 8
) (
   input  logic           clk,
   input  logic           rst,
   output logic           imem_req,
   output logic [PAW-1:0] imem_addr,
   input  logic           imem_ack,
   input  logic [15:0]    imem_rdata,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [DAW-1:0] dmem_addr,
   output logic [DW-1:0]  dmem_wdata,
   input  logic           dmem_ack,
   input  logic [DW-1:0]  dmem_rdata,
   output logic           halted,
   output logic [PAW-1:0] pc_out
);

   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_AND  = 5'h03;
   localparam logic [4:0] OP_OR   = 5'h04;
   localparam logic [4:0] OP_XOR  = 5'h05;
   localparam logic [4:0] OP_ADDI = 5'h06;
   localparam logic [4:0] OP_LDI  = 5'h07;
   localparam logic [4:0] OP_LD   = 5'h08;
   localparam logic [4:0] OP_ST   = 5'h09;
   localparam logic [4:0] OP_JMP  = 5'h0A;
   localparam logic [4:0] OP_BRZ  = 5'h0B;
   localparam logic [4:0] OP_BRC  = 5'h0C;
   localparam logic [4:0] OP_HALT = 5'h0D;

   typedef enum logic [2:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   state_t         state_q, state_d;
   logic [PAW-1:0] pc_q, pc_d;
   logic [15:0]    ir_q, ir_d;
   logic           z_q, z_d;
   logic           c_q, c_d;
   logic [DW-1:0]  regs_q [NREG];
   logic [DW-1:0]  regs_d [NREG];

   logic [4:0]     op;
   logic [2:0]     rd_idx;
   logic [2:0]     rs_idx;
   logic [DW-1:0]  k_dw;
   logic [PAW-1:0] k_pc;
   logic [DW-1:0]  rd_val;
   logic [DW-1:0]  rs_val;
   logic [DW-1:0]  alu_res;
   logic           alu_c;
   logic [DW:0]    sum;
   logic           is_alu;
   logic           is_mem;
   logic           is_halt;
   logic           is_exec;
   logic           wr_en;
   logic [DW-1:0]  wr_data;

   assign op     = ir_q[15:11];
   assign rd_idx = ir_q[10:8];
   assign rs_idx = ir_q[7:5];
   assign k_dw   = DW'(ir_q[7:0]);
   assign k_pc   = PAW'(ir_q[7:0]);

   assign is_alu  = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_AND) || (op == OP_OR) ||
                    (op == OP_XOR) || (op == OP_ADDI);
   assign is_mem  = (op == OP_LD) || (op == OP_ST);
   assign is_halt = (op == OP_HALT);
   assign is_exec = is_alu || (op == OP_LDI) || (op == OP_JMP) ||
                    (op == OP_BRZ) || (op == OP_BRC);

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = dmem_req && (op == OP_ST);
   assign dmem_addr  = rs_val[DAW-1:0];
   assign dmem_wdata = rd_val;
   assign halted     = (state_q == S_HALT);
   assign pc_out     = pc_q;

   // register read ports; indices beyond NREG read as zero
   always_comb begin
      rd_val = '0;
      rs_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rd_idx == 3'(i)) rd_val = regs_q[i];
         if (rs_idx == 3'(i)) rs_val = regs_q[i];
      end
   end

   // ALU result and carry/borrow for the flag-setting ops
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      sum     = '0;
      unique case (op)
         OP_ADD: begin
            sum     = {1'b0, rd_val} + {1'b0, rs_val};
            alu_res = sum[DW-1:0];
            alu_c   = sum[DW];
         end
         OP_SUB: begin
            alu_res = rd_val - rs_val;
            alu_c   = (rd_val < rs_val);
         end
         OP_AND: alu_res = rd_val & rs_val;
         OP_OR:  alu_res = rd_val | rs_val;
         OP_XOR: alu_res = rd_val ^ rs_val;
         OP_ADDI: begin
            sum     = {1'b0, rd_val} + {1'b0, k_dw};
            alu_res = sum[DW-1:0];
            alu_c   = sum[DW];
         end
         default: ;
      endcase
   end

   // sequencer: next state, PC, instruction latch, flags, write-back
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;
      c_d     = c_q;
      wr_en   = 1'b0;
      wr_data = '0;
      unique case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PAW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               is_mem:  state_d = S_MEM;
               is_halt: state_d = S_HALT;
               is_exec: state_d = S_EXEC;
               default: state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_alu) begin
               wr_en   = 1'b1;
               wr_data = alu_res;
               z_d     = (alu_res == '0);
               c_d     = alu_c;
            end
            if (op == OP_LDI) begin
               wr_en   = 1'b1;
               wr_data = k_dw;
            end
            if (op == OP_JMP) pc_d = k_pc;
            if ((op == OP_BRZ) && z_q) pc_d = k_pc;
            if ((op == OP_BRC) && c_q) pc_d = k_pc;
         end
         S_MEM: begin
            if (dmem_ack) begin
               state_d = S_FETCH;
               if (op == OP_LD) begin
                  wr_en   = 1'b1;
                  wr_data = dmem_rdata;
               end
            end
         end
         S_HALT: ;
         default: state_d = S_START;
      endcase
   end

   // register file write; out-of-range indices are dropped
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (rd_idx == 3'(i))) regs_d[i] = wr_data;
      end
   end

   // architectural state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_START;
         pc_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed bench for mc_core, default config plus a
// DW=16 / NREG=4 / PAW=4 instance.
module tb_mc_core;

   localparam logic [4:0] NOP  = 5'h00;
   localparam logic [4:0] ADD  = 5'h01;
   localparam logic [4:0] SUB  = 5'h02;
   localparam logic [4:0] XOR_ = 5'h05;
   localparam logic [4:0] ADDI = 5'h06;
   localparam logic [4:0] LDI  = 5'h07;
   localparam logic [4:0] LD   = 5'h08;
   localparam logic [4:0] ST   = 5'h09;
   localparam logic [4:0] JMP  = 5'h0A;
   localparam logic [4:0] BRZ  = 5'h0B;
   localparam logic [4:0] BRC  = 5'h0C;
   localparam logic [4:0] HLT  = 5'h0D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic clr_a, clr_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   dwait;

   logic        imem_req_a, imem_ack_a, dmem_req_a, dmem_we_a;
   logic        dmem_ack_a, halted_a;
   logic [7:0]  imem_addr_a, dmem_addr_a, dmem_wdata_a;
   logic [7:0]  dmem_rdata_a, pc_out_a;
   logic [15:0] imem_rdata_a;

   logic        imem_req_b, imem_ack_b, dmem_req_b, dmem_we_b;
   logic        dmem_ack_b, halted_b;
   logic [3:0]  imem_addr_b, pc_out_b;
   logic [7:0]  dmem_addr_b;
   logic [15:0] imem_rdata_b, dmem_wdata_b, dmem_rdata_b;

   logic [15:0] imem_a [256];
   logic [7:0]  dmem_a [256];
   logic [15:0] imem_b [16];
   logic [15:0] dmem_b [256];
   int          fetch_cyc [256];
   int          icnt, dcnt, st_cnt, slow_cnt, b4cnt;

   mc_core u_a (
      .clk(clk), .rst(rst_a),
      .imem_req(imem_req_a), .imem_addr(imem_addr_a),
      .imem_ack(imem_ack_a), .imem_rdata(imem_rdata_a),
      .dmem_req(dmem_req_a), .dmem_we(dmem_we_a),
      .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
      .dmem_ack(dmem_ack_a), .dmem_rdata(dmem_rdata_a),
      .halted(halted_a), .pc_out(pc_out_a)
   );

   mc_core #(.DW(16), .NREG(4), .PAW(4), .DAW(8)) u_b (
      .clk(clk), .rst(rst_b),
      .imem_req(imem_req_b), .imem_addr(imem_addr_b),
      .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
      .dmem_req(dmem_req_b), .dmem_we(dmem_we_b),
      .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
      .dmem_ack(dmem_ack_b), .dmem_rdata(dmem_rdata_b),
      .halted(halted_b), .pc_out(pc_out_b)
   );

   assign imem_rdata_a = imem_a[imem_addr_a];
   assign imem_ack_a   = imem_req_a &&
                         (icnt >= ((imem_addr_a == 8'h34) ? 4 : 0));
   assign dmem_rdata_a = dmem_a[dmem_addr_a];
   assign dmem_ack_a   = dmem_req_a && (dcnt >= dwait);

   assign imem_rdata_b = imem_b[imem_addr_b];
   assign imem_ack_b   = imem_req_b;
   assign dmem_rdata_b = dmem_b[dmem_addr_b];
   assign dmem_ack_b   = dmem_req_b;

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         icnt <= 0;
         dcnt <= 0;
      end else begin
         icnt <= (imem_req_a && !imem_ack_a) ? icnt + 1 : 0;
         dcnt <= (dmem_req_a && !dmem_ack_a) ? dcnt + 1 : 0;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr_a) begin
         for (int i = 0; i < 256; i++) begin
            fetch_cyc[i] <= -1;
            dmem_a[i]    <= 8'hEE;
         end
         st_cnt   <= 0;
         slow_cnt <= 0;
      end else begin
         if (imem_req_a && imem_ack_a) fetch_cyc[imem_addr_a] <= cyc;
         if (dmem_req_a && dmem_ack_a && dmem_we_a)
            dmem_a[dmem_addr_a] <= dmem_wdata_a;
         if (dmem_req_a && dmem_we_a && dmem_addr_a == 8'h10 &&
             dmem_wdata_a == 8'h5A)
            st_cnt <= st_cnt + 1;
         if (imem_req_a && imem_addr_a == 8'h34) slow_cnt <= slow_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (clr_b) begin
         for (int i = 0; i < 256; i++) dmem_b[i] <= 16'hAAAA;
         dmem_b[0] <= 16'hFF01;
         b4cnt <= 0;
      end else begin
         if (dmem_req_b && dmem_ack_b && dmem_we_b)
            dmem_b[dmem_addr_b] <= dmem_wdata_b;
         if (imem_req_b && imem_ack_b && imem_addr_b == 4'h4)
            b4cnt <= b4cnt + 1;
      end
   end

   function automatic logic [15:0] enc_r(input logic [4:0] op,
                                         input logic [2:0] rd,
                                         input logic [2:0] rs);
      return {op, rd, rs, 5'b0};
   endfunction

   function automatic logic [15:0] enc_k(input logic [4:0] op,
                                         input logic [2:0] rd,
                                         input logic [7:0] k);
      return {op, rd, k};
   endfunction

   task automatic load_programs();
      for (int i = 0; i < 256; i++) imem_a[i] = enc_k(HLT, 3'd0, 8'h00);
      imem_a[8'h00] = enc_k(LDI, 3'd1, 8'hFF);
      imem_a[8'h01] = enc_k(LDI, 3'd2, 8'h01);
      imem_a[8'h02] = enc_r(ADD, 3'd1, 3'd2);
      imem_a[8'h03] = enc_k(BRZ, 3'd0, 8'h20);
      imem_a[8'h20] = enc_k(BRC, 3'd0, 8'h30);
      imem_a[8'h30] = enc_r(SUB, 3'd2, 3'd1);
      imem_a[8'h31] = enc_k(BRC, 3'd0, 8'h40);
      imem_a[8'h32] = enc_k(BRZ, 3'd0, 8'h50);
      imem_a[8'h33] = enc_k(LDI, 3'd3, 8'h10);
      imem_a[8'h34] = enc_k(LDI, 3'd4, 8'h5A);
      imem_a[8'h35] = enc_r(ST, 3'd4, 3'd3);
      imem_a[8'h36] = enc_k(LDI, 3'd5, 8'h11);
      imem_a[8'h37] = enc_r(ST, 3'd1, 3'd5);
      imem_a[8'h38] = enc_k(LDI, 3'd5, 8'h12);
      imem_a[8'h39] = enc_r(ST, 3'd2, 3'd5);
      imem_a[8'h3A] = enc_k(LDI, 3'd6, 8'h10);
      imem_a[8'h3B] = enc_r(LD, 3'd7, 3'd6);
      imem_a[8'h3C] = enc_r(XOR_, 3'd7, 3'd4);
      imem_a[8'h3D] = enc_k(BRZ, 3'd0, 8'h60);
      imem_a[8'h60] = enc_k(LDI, 3'd5, 8'h13);
      imem_a[8'h61] = enc_r(ST, 3'd7, 3'd5);
      imem_a[8'h62] = enc_k(NOP, 3'd0, 8'h00);
      imem_a[8'h63] = enc_k(HLT, 3'd0, 8'h00);
      for (int i = 0; i < 16; i++) imem_b[i] = enc_k(HLT, 3'd0, 8'h00);
      imem_b[0]  = enc_k(LDI, 3'd0, 8'h00);
      imem_b[1]  = enc_r(LD, 3'd3, 3'd0);
      imem_b[2]  = enc_k(ADDI, 3'd3, 8'hFF);
      imem_b[3]  = enc_k(BRC, 3'd0, 8'h05);
      imem_b[5]  = enc_k(LDI, 3'd2, 8'h10);
      imem_b[6]  = enc_k(LDI, 3'd6, 8'h05);
      imem_b[7]  = enc_r(ADD, 3'd1, 3'd6);
      imem_b[8]  = enc_r(ST, 3'd3, 3'd2);
      imem_b[9]  = enc_k(ADDI, 3'd2, 8'h01);
      imem_b[10] = enc_r(ST, 3'd1, 3'd2);
      imem_b[11] = enc_k(JMP, 3'd0, 8'hFF);
      imem_b[15] = enc_k(NOP, 3'd0, 8'h00);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_a = 1'b0;
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (imem_req_a !== 1'b0 || dmem_req_a !== 1'b0 || dmem_we_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_reqs got %b%b%b want 000",
                  imem_req_a, dmem_req_a, dmem_we_a);
      end
      checks++;
      if (halted_a !== 1'b0 || pc_out_a !== 8'h00) begin
         errors++;
         $display("FAIL rst_pc got halted=%b pc=%h want 0/00", halted_a, pc_out_a);
      end
      rst_a = 1'b1;
      #1;
      checks++;
      if (imem_req_a !== 1'b0) begin
         errors++;
         $display("FAIL start_req got %b want 0", imem_req_a);
      end
      @(negedge clk);
      checks++;
      if (imem_req_a !== 1'b1 || imem_addr_a !== 8'h00 || pc_out_a !== 8'h00) begin
         errors++;
         $display("FAIL first_fetch got req=%b addr=%h pc=%h want 1/00/00",
                  imem_req_a, imem_addr_a, pc_out_a);
      end
   endtask

   task automatic run_to_halt(input int budget);
      int n;
      n = 0;
      while (halted_a !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (halted_a !== 1'b1) begin
         errors++;
         $display("FAIL halt_timeout got halted=%b want 1", halted_a);
      end
   endtask

   task automatic test_alu_flags();
      checks++;
      if (fetch_cyc[1] - fetch_cyc[0] !== 3 || fetch_cyc[2] - fetch_cyc[1] !== 3 ||
          fetch_cyc[3] - fetch_cyc[2] !== 3) begin
         errors++;
         $display("FAIL alu_latency got %0d %0d %0d want 3 3 3",
                  fetch_cyc[1] - fetch_cyc[0], fetch_cyc[2] - fetch_cyc[1],
                  fetch_cyc[3] - fetch_cyc[2]);
      end
      checks++;
      if (dmem_a[8'h11] !== 8'h00) begin
         errors++;
         $display("FAIL add_result got %h want 00", dmem_a[8'h11]);
      end
      checks++;
      if (dmem_a[8'h12] !== 8'h01) begin
         errors++;
         $display("FAIL sub_result got %h want 01", dmem_a[8'h12]);
      end
      checks++;
      if (dmem_a[8'h13] !== 8'h00) begin
         errors++;
         $display("FAIL ld_xor_result got %h want 00", dmem_a[8'h13]);
      end
   endtask

   task automatic test_branches();
      checks++;
      if (fetch_cyc[8'h20] - fetch_cyc[3] !== 3 || fetch_cyc[4] !== -1) begin
         errors++;
         $display("FAIL brz_taken got dt=%0d f4=%0d want 3/-1",
                  fetch_cyc[8'h20] - fetch_cyc[3], fetch_cyc[4]);
      end
      checks++;
      if (fetch_cyc[8'h30] === -1) begin
         errors++;
         $display("FAIL brc_taken got f30=%0d want fetched", fetch_cyc[8'h30]);
      end
      checks++;
      if (fetch_cyc[8'h32] - fetch_cyc[8'h31] !== 3 || fetch_cyc[8'h40] !== -1 ||
          fetch_cyc[8'h50] !== -1) begin
         errors++;
         $display("FAIL br_not_taken got dt=%0d f40=%0d f50=%0d want 3/-1/-1",
                  fetch_cyc[8'h32] - fetch_cyc[8'h31], fetch_cyc[8'h40],
                  fetch_cyc[8'h50]);
      end
      checks++;
      if (fetch_cyc[8'h60] === -1 || fetch_cyc[8'h3E] !== -1) begin
         errors++;
         $display("FAIL brz_after_xor got f60=%0d f3e=%0d want fetched/-1",
                  fetch_cyc[8'h60], fetch_cyc[8'h3E]);
      end
   endtask

   task automatic test_wait_states();
      checks++;
      if (slow_cnt !== 5 || fetch_cyc[8'h34] - fetch_cyc[8'h33] !== 7) begin
         errors++;
         $display("FAIL imem_wait got cnt=%0d dt=%0d want 5/7",
                  slow_cnt, fetch_cyc[8'h34] - fetch_cyc[8'h33]);
      end
      checks++;
      if (st_cnt !== 3 || fetch_cyc[8'h36] - fetch_cyc[8'h35] !== 5) begin
         errors++;
         $display("FAIL dmem_wait got cnt=%0d dt=%0d want 3/5",
                  st_cnt, fetch_cyc[8'h36] - fetch_cyc[8'h35]);
      end
      checks++;
      if (dmem_a[8'h10] !== 8'h5A) begin
         errors++;
         $display("FAIL st_data got %h want 5a", dmem_a[8'h10]);
      end
      checks++;
      if (fetch_cyc[8'h63] - fetch_cyc[8'h62] !== 2) begin
         errors++;
         $display("FAIL nop_latency got %0d want 2",
                  fetch_cyc[8'h63] - fetch_cyc[8'h62]);
      end
   endtask

   task automatic test_halt();
      int reqs;
      reqs = 0;
      checks++;
      if (pc_out_a !== 8'h64) begin
         errors++;
         $display("FAIL halt_pc got %h want 64", pc_out_a);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req_a || dmem_req_a || !halted_a) reqs++;
      end
      checks++;
      if (reqs !== 0) begin
         errors++;
         $display("FAIL halt_quiet got %0d bad cycles want 0", reqs);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      @(negedge clk);
      rst_a = 1'b0;
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      dwait = 50;
      rst_a = 1'b1;
      n = 0;
      while (dmem_req_a !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (dmem_req_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_wait_req got %b want 1", dmem_req_a);
      end
      repeat (2) @(negedge clk);
      #2;
      rst_a = 1'b0;
      #1;
      checks++;
      if (dmem_req_a !== 1'b0 || dmem_we_a !== 1'b0 || pc_out_a !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset got req=%b we=%b pc=%h want 0/0/00",
                  dmem_req_a, dmem_we_a, pc_out_a);
      end
      checks++;
      if (dmem_a[8'h10] !== 8'hEE) begin
         errors++;
         $display("FAIL mid_no_store got %h want ee", dmem_a[8'h10]);
      end
      @(negedge clk);
      dwait = 2;
      rst_a = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req_a !== 1'b1 || imem_addr_a !== 8'h00) begin
         errors++;
         $display("FAIL restart got req=%b addr=%h want 1/00",
                  imem_req_a, imem_addr_a);
      end
      run_to_halt(600);
      checks++;
      if (dmem_a[8'h12] !== 8'h01 || dmem_a[8'h10] !== 8'h5A) begin
         errors++;
         $display("FAIL rerun got %h %h want 01 5a", dmem_a[8'h12], dmem_a[8'h10]);
      end
   endtask

   task automatic test_params();
      int  n;
      bit  seen_f;
      logic [3:0] next_addr;
      seen_f    = 1'b0;
      next_addr = 4'hX;
      @(negedge clk);
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      rst_b = 1'b1;
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (!seen_f) begin
            if (imem_req_b && imem_addr_b == 4'hF) seen_f = 1'b1;
         end else if (imem_req_b) begin
            next_addr = imem_addr_b;
            break;
         end
      end
      checks++;
      if (!seen_f || next_addr !== 4'h0) begin
         errors++;
         $display("FAIL jmp_wrap got seenF=%b next=%h want 1/0", seen_f, next_addr);
      end
      checks++;
      if (dmem_b[8'h10] !== 16'h0000) begin
         errors++;
         $display("FAIL addi_wrap got %h want 0000", dmem_b[8'h10]);
      end
      checks++;
      if (b4cnt !== 0) begin
         errors++;
         $display("FAIL addi_carry got %0d trap fetches want 0", b4cnt);
      end
      checks++;
      if (dmem_b[8'h11] !== 16'h0000 || dmem_b[8'h05] !== 16'hAAAA) begin
         errors++;
         $display("FAIL nreg_drop got %h %h want 0000 aaaa",
                  dmem_b[8'h11], dmem_b[8'h05]);
      end
      checks++;
      if (halted_b !== 1'b0) begin
         errors++;
         $display("FAIL b_halted got %b want 0", halted_b);
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      clr_a = 1'b0;
      clr_b = 1'b0;
      dwait = 2;
      load_programs();
      #1 rst_b = 1'b0;
      test_reset();
      run_to_halt(600);
      test_alu_flags();
      test_branches();
      test_wait_states();
      test_halt();
      test_mid_reset();
      test_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle processor core with a handshaked memory interface. It generalises the fixed 8-bit single-cycle datapath to a configurable data width, register count and address widths. It fetches 16-bit instructions through a req/ack port and runs a FETCH/DECODE/EXEC/MEM state machine. A separate req/ack data port tolerates wait states on both memories. It sits above external program and data memories, replacing the hard-wired PC/ALU/GPR/control assembly.

## Interface
- DW, 8: data/register width, 8..32.
- NREG, 8: number of general-purpose registers, 2..8.
- PAW, 8: program address width (PC width), 4..16.
- DAW, 8: data address width, 4..DW.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction fetch request; high only in FETCH.
- imem_addr  out  PAW  fetch address, equal to PC.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request; high only in MEM.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DAW  low DAW bits of rs.
- dmem_wdata  out  DW  rd value for stores.
- dmem_ack  in  1  access complete; rdata is valid for loads.
- dmem_rdata  in  DW  load data.
- halted  out  1  high in HALT.
- pc_out  out  PAW  current PC, for debug.

## Operation
- Instruction format: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] k. k is zero-extended to DW, or truncated/zero-extended to PAW for targets.
- Opcodes:
  - 00 NOP
  - 01 ADD rd=rd+rs
  - 02 SUB rd=rd-rs
  - 03 AND
  - 04 OR
  - 05 XOR
  - 06 ADDI rd=rd+k
  - 07 LDI rd=k
  - 08 LD rd=mem[rs]
  - 09 ST mem[rs]=rd
  - 0A JMP k
  - 0B BRZ k (if Z)
  - 0C BRC k (if C)
  - 0D HALT
  - All other opcodes execute as NOP.
- States: START, FETCH, DECODE, EXEC, MEM, HALT.
  - START → FETCH unconditionally.
  - FETCH holds until imem_ack, then latches the instruction, sets PC=PC+1 (wraps 2^PAW-1 → 0) and goes to DECODE.
  - DECODE → MEM for LD/ST, HALT for HALT, FETCH for NOP/illegal, otherwise EXEC.
  - EXEC → FETCH.
  - MEM holds until dmem_ack, then goes to FETCH.
  - HALT is terminal until reset.
- Flags Z and C are updated only by ADD, SUB, AND, OR, XOR and ADDI, in EXEC.
  - Z = (result == 0).
  - C = carry-out of the DW-bit add, or borrow (rd<rs unsigned) for SUB; cleared by logic ops.
  - Results truncate to DW bits.
- LDI, LD, branches and ST leave the flags unchanged.
- Register index ≥ NREG: the write is dropped and the read returns 0.
- Branch taken: PC=k in EXEC. Not taken: PC is unchanged (already incremented).
- LD writes rd with dmem_rdata in the ack cycle. ST writes nothing.

## Timing
- Reset (rst=0): effective immediately.
  - state=START, PC=0, all registers 0, Z=C=0.
  - imem_req=dmem_req=dmem_we=0, halted=0, pc_out=0, latched instruction=0.
- Requests are combinational from state. Addresses and wdata are stable for the whole request.
- A request drops in the cycle after its ack edge.
- Ack while the corresponding req is low is ignored.
- Zero-wait latency (ack in first request cycle):
  - ALU/LDI/branch: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ST: 3 cycles (FETCH, DECODE, MEM).
  - NOP: 2 cycles.
- Each wait cycle adds one cycle in FETCH or MEM.
- First imem_req is in the second rising edge after rst is released (START lasts one cycle).
- Register write and flag update are visible to the DECODE of the next instruction. There are no hazards.
- Reset asserted mid-request drops req asynchronously. No partial register write is performed.
- In HALT, no requests are issued and acks are ignored.

## Test plan
- Reset/start: hold rst=0 for 3 cycles, then release with zero-wait memories. Required: imem_req=0 in the first cycle, then imem_req=1 with imem_addr=0; pc_out=0 before the first ack.
- ALU and flags (DW=8): program LDI r1,0xFF; LDI r2,0x01; ADD r1,r2. Required: r1=0x00, Z=1, C=1, each instruction 3 cycles. Then SUB r2,r1 → r2=0x01, Z=0, C=0.
- Wait states: hold imem_ack low 4 cycles for one fetch, and dmem_ack low 2 cycles on ST [r3],r4 with r3=0x10, r4=0x5A. Required: imem_addr stable and imem_req high throughout; dmem_addr=0x10, dmem_wdata=0x5A, dmem_we=1 for 3 cycles.
- Branches: Z=1 then BRZ 0x20 → next imem_addr=0x20. With C=0, BRC 0x40 → falls through to PC+1. JMP 0xFF with PAW=4 → PC=0xF; the next fetch wraps to 0x0.
- Parameters: DW=16, NREG=4. ADDI r3,0xFF on r3=0xFF01 → r3=0x0000, C=1. LDI r6,5 → no write; a later ADD r1,r6 reads r6 as 0.
- HALT and mid-op reset: after HALT, halted=1 and no requests occur for 10 cycles. Assert rst during a MEM wait → dmem_req falls in the same cycle, and execution restarts at PC=0.
